// File: rtl/wordle_pkg.sv
// Shared widths, result codes and the one-hot game state encoding for the Wordle core.
// Pure declarations; no clocked logic lives here.
// Optional history feature is selected elsewhere with WORDLE_HISTORY_EN.
package wordle_pkg;

  localparam int LETTER_W   = 5;
  localparam int WORD_LEN   = 5;
  localparam int LETTER_MAX = 25;
  localparam int WORD_W     = LETTER_W * WORD_LEN;
  localparam int RES_W      = 2 * WORD_LEN;

  localparam logic [1:0] RES_GRAY   = 2'b00;
  localparam logic [1:0] RES_YELLOW = 2'b01;
  localparam logic [1:0] RES_GREEN  = 2'b10;

  // One-hot so the display flags are simply the state bits.
  typedef enum logic [9:0] {
    ST_I       = 10'b00_0000_0001,
    ST_L1      = 10'b00_0000_0010,
    ST_L2      = 10'b00_0000_0100,
    ST_L3      = 10'b00_0000_1000,
    ST_L4      = 10'b00_0001_0000,
    ST_L5      = 10'b00_0010_0000,
    ST_CHECK   = 10'b00_0100_0000,
    ST_WRONG   = 10'b00_1000_0000,
    ST_CORRECT = 10'b01_0000_0000,
    ST_DONE    = 10'b10_0000_0000
  } state_t;

  function automatic logic letter_valid(input logic [LETTER_W-1:0] c);
    return c <= LETTER_W'(LETTER_MAX);
  endfunction

endpackage

// File: rtl/wordle_scorer.sv
// Scores a 5-letter guess against the target with standard duplicate-letter rules.
// Latency: 6 cycles after start (greens first, then one position per cycle); done marks the last cycle.
// No backpressure: once started it runs to completion unless cleared or reset.
module wordle_scorer
  import wordle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clr,
  input  logic [WORD_W-1:0] guess,
  input  logic [WORD_W-1:0] target,
  output logic              done,
  output logic              all_green,
  output logic [RES_W-1:0]  result
);

  logic                active;
  logic [2:0]          sub_cnt;
  logic [WORD_LEN-1:0] used;
  logic [WORD_LEN-1:0] used_nxt;
  logic [RES_W-1:0]    result_nxt;
  logic                found;

  // Step 0 marks exact matches; step j gives position j-1 a yellow from the lowest unused target slot.
  always_comb begin
    used_nxt   = used;
    result_nxt = result;
    found      = 1'b0;
    if (active) begin
      if (sub_cnt == 3'd0) begin
        for (int i = 0; i < WORD_LEN; i++) begin
          if (guess[i*LETTER_W +: LETTER_W] == target[i*LETTER_W +: LETTER_W]) begin
            result_nxt[i*2 +: 2] = RES_GREEN;
            used_nxt[i]          = 1'b1;
          end
        end
      end else begin
        for (int p = 0; p < WORD_LEN; p++) begin
          if (sub_cnt == 3'(p + 1) && result[p*2 +: 2] != RES_GREEN) begin
            for (int k = 0; k < WORD_LEN; k++) begin
              if (!found && !used[k] &&
                  target[k*LETTER_W +: LETTER_W] == guess[p*LETTER_W +: LETTER_W]) begin
                found                = 1'b1;
                used_nxt[k]          = 1'b1;
                result_nxt[p*2 +: 2] = RES_YELLOW;
              end
            end
          end
        end
      end
    end
  end

  // Sequencer and result/used-mask registers; a new start wipes any previous score.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      sub_cnt <= 3'd0;
      used    <= '0;
      result  <= '0;
    end else if (clr || start) begin
      active  <= start;
      sub_cnt <= 3'd0;
      used    <= '0;
      result  <= '0;
    end else if (active) begin
      result  <= result_nxt;
      used    <= used_nxt;
      sub_cnt <= sub_cnt + 3'd1;
      if (sub_cnt == 3'd5) active <= 1'b0;
    end
  end

  // Greens are final after step 0, so the registered result already answers "all green" on the last step.
  always_comb begin
    all_green = 1'b1;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (result[i*2 +: 2] != RES_GREEN) all_green = 1'b0;
    end
  end

  assign done = active && (sub_cnt == 3'd5);

endmodule

// File: rtl/wordle_game_fsm.sv
// Wordle game core: letter entry, 6-cycle scoring, guess counting and one-hot display flags.
// Latency: letter entry 1 cycle; Enter in L5 gives the scored result 7 cycles later.
// No backpressure: Enter/Back are single-cycle pulses; pulses arriving during scoring are dropped.
// Optional per-guess history array enabled by defining WORDLE_HISTORY_EN.
module wordle_game_fsm
  import wordle_pkg::*;
#(
  parameter int MAX_GUESSES = 6
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Enter,
  input  logic                Back,
  input  logic [LETTER_W-1:0] CharIn,
  input  logic [WORD_W-1:0]   Target,
  output logic                q_I,
  output logic                q_L1,
  output logic                q_L2,
  output logic                q_L3,
  output logic                q_L4,
  output logic                q_L5,
  output logic                q_Check,
  output logic                q_Wrong,
  output logic                q_Correct,
  output logic                q_Done,
  output logic [2:0]          GuessNumber,
  output logic [WORD_W-1:0]   GuessWord,
  output logic [RES_W-1:0]    Result,
  output logic                Won,
  input  logic [2:0]          HistSel,
  output logic [WORD_W-1:0]   HistWord,
  output logic [RES_W-1:0]    HistResult
);

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] target_q;
  logic              in_letter;
  logic [2:0]        letter_idx;
  logic              char_ok;
  logic              game_start;
  logic              letter_wr;
  logic              letter_del;
  logic              score_start;
  logic              score_done;
  logic              score_all_green;
  logic              out_of_guesses;
  logic              retry;

  assign char_ok        = letter_valid(CharIn);
  assign game_start     = (state == ST_I) && Enter;
  assign letter_wr      = in_letter && Enter && char_ok;
  assign letter_del     = in_letter && !Enter && Back && (letter_idx != 3'd0);
  assign score_start    = (state == ST_L5) && Enter && char_ok;
  assign out_of_guesses = (GuessNumber == 3'(MAX_GUESSES));
  assign retry          = (state == ST_WRONG) && Enter && !out_of_guesses;

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_I;
    else       state <= state_nxt;
  end

  // Next-state: Enter takes priority over Back; invalid letters leave the state alone.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_I:       if (Enter) state_nxt = ST_L1;
      ST_L1:      if (Enter && char_ok) state_nxt = ST_L2;
      ST_L2:      if (Enter) begin if (char_ok) state_nxt = ST_L3; end
                  else if (Back) state_nxt = ST_L1;
      ST_L3:      if (Enter) begin if (char_ok) state_nxt = ST_L4; end
                  else if (Back) state_nxt = ST_L2;
      ST_L4:      if (Enter) begin if (char_ok) state_nxt = ST_L5; end
                  else if (Back) state_nxt = ST_L3;
      ST_L5:      if (Enter) begin if (char_ok) state_nxt = ST_CHECK; end
                  else if (Back) state_nxt = ST_L4;
      ST_CHECK:   if (score_done) state_nxt = score_all_green ? ST_CORRECT : ST_WRONG;
      ST_WRONG:   if (Enter) state_nxt = out_of_guesses ? ST_DONE : ST_L1;
      ST_CORRECT: if (Enter) state_nxt = ST_DONE;
      ST_DONE:    if (Enter) state_nxt = ST_I;
      default:    state_nxt = ST_I;
    endcase
  end

  // Outputs: one-hot flags straight from the state register, plus the letter slot being edited.
  always_comb begin
    {q_Done, q_Correct, q_Wrong, q_Check, q_L5, q_L4, q_L3, q_L2, q_L1, q_I} = state;
    in_letter  = 1'b1;
    letter_idx = 3'd0;
    case (state)
      ST_L1:   letter_idx = 3'd0;
      ST_L2:   letter_idx = 3'd1;
      ST_L3:   letter_idx = 3'd2;
      ST_L4:   letter_idx = 3'd3;
      ST_L5:   letter_idx = 3'd4;
      default: in_letter  = 1'b0;
    endcase
  end

  // Game datapath: target latch, guess letters, guess counter and win flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      target_q    <= '0;
      GuessWord   <= '0;
      GuessNumber <= 3'd0;
      Won         <= 1'b0;
    end else begin
      if (game_start) begin
        target_q    <= Target;
        GuessWord   <= '0;
        GuessNumber <= 3'd0;
        Won         <= 1'b0;
      end else if (retry) begin
        GuessWord <= '0;
      end else begin
        for (int i = 0; i < WORD_LEN; i++) begin
          if (letter_wr && letter_idx == 3'(i))
            GuessWord[i*LETTER_W +: LETTER_W] <= CharIn;
          if (letter_del && letter_idx == 3'(i + 1))
            GuessWord[i*LETTER_W +: LETTER_W] <= '0;
        end
      end
      if (score_done) begin
        GuessNumber <= GuessNumber + 3'd1;
        if (score_all_green) Won <= 1'b1;
      end
    end
  end

  wordle_scorer u_scorer (
    .clk       (Clk),
    .rst       (Reset),
    .start     (score_start),
    .clr       (game_start || retry),
    .guess     (GuessWord),
    .target    (target_q),
    .done      (score_done),
    .all_green (score_all_green),
    .result    (Result)
  );

`ifdef WORDLE_HISTORY_EN
  logic [WORD_W-1:0] hist_word [MAX_GUESSES];
  logic [RES_W-1:0]  hist_res  [MAX_GUESSES];
  logic              hist_wr;

  // Row capture one cycle after scoring ends, when GuessNumber and Result are both final.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hist_wr    <= 1'b0;
      HistWord   <= '0;
      HistResult <= '0;
      for (int i = 0; i < MAX_GUESSES; i++) begin
        hist_word[i] <= '0;
        hist_res[i]  <= '0;
      end
    end else begin
      hist_wr <= score_done;
      for (int i = 0; i < MAX_GUESSES; i++) begin
        if (game_start) begin
          hist_word[i] <= '0;
          hist_res[i]  <= '0;
        end else if (hist_wr && GuessNumber == 3'(i + 1)) begin
          hist_word[i] <= GuessWord;
          hist_res[i]  <= Result;
        end
      end
      HistWord   <= '0;
      HistResult <= '0;
      for (int i = 0; i < MAX_GUESSES; i++) begin
        if (HistSel == 3'(i)) begin
          HistWord   <= hist_word[i];
          HistResult <= hist_res[i];
        end
      end
    end
  end
`else
  logic unused_hist_sel;
  assign unused_hist_sel = ^HistSel;
  assign HistWord        = '0;
  assign HistResult      = '0;
`endif

endmodule

// File: tb/tb_wordle_game_fsm.sv
// Self-checking bench for wordle_game_fsm: behavioural game model compared every cycle,
// plus directed literal checks of scoring, letter editing, guess limits and reset.
// History checks run only when WORDLE_HISTORY_EN is defined.
module tb_wordle_game_fsm;

  localparam int MAXG = 6;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Enter = 1'b0;
  logic        Back = 1'b0;
  logic [4:0]  CharIn = 5'd0;
  logic [24:0] Target = 25'd0;
  logic [2:0]  HistSel = 3'd0;
  logic        q_I, q_L1, q_L2, q_L3, q_L4, q_L5, q_Check, q_Wrong, q_Correct, q_Done;
  logic [2:0]  GuessNumber;
  logic [24:0] GuessWord;
  logic [9:0]  Result;
  logic        Won;
  logic [24:0] HistWord;
  logic [9:0]  HistResult;

  wordle_game_fsm #(.MAX_GUESSES(MAXG)) dut (
    .Clk(Clk), .Reset(Reset), .Enter(Enter), .Back(Back), .CharIn(CharIn), .Target(Target),
    .q_I(q_I), .q_L1(q_L1), .q_L2(q_L2), .q_L3(q_L3), .q_L4(q_L4), .q_L5(q_L5),
    .q_Check(q_Check), .q_Wrong(q_Wrong), .q_Correct(q_Correct), .q_Done(q_Done),
    .GuessNumber(GuessNumber), .GuessWord(GuessWord), .Result(Result), .Won(Won),
    .HistSel(HistSel), .HistWord(HistWord), .HistResult(HistResult)
  );

  always #5 Clk = ~Clk;

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] pack(input int a, input int b, input int c, input int d, input int e);
    return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  // Letter-count scoring: greens first, then yellows left to right while unmatched copies remain.
  function automatic logic [9:0] score(input logic [24:0] g, input logic [24:0] t);
    int          cnt [32];
    logic [9:0]  r;
    logic [4:0]  gl, tl;
    r = '0;
    for (int i = 0; i < 32; i++) cnt[i] = 0;
    for (int i = 0; i < 5; i++) begin
      gl = g[i*5 +: 5];
      tl = t[i*5 +: 5];
      if (gl == tl) r[i*2 +: 2] = 2'b10;
      else cnt[tl]++;
    end
    for (int i = 0; i < 5; i++) begin
      gl = g[i*5 +: 5];
      if (r[i*2 +: 2] != 2'b10 && cnt[gl] > 0) begin
        r[i*2 +: 2] = 2'b01;
        cnt[gl]--;
      end
    end
    return r;
  endfunction

  // Game model: m_st 0=I, 1..5=L1..L5, 6=CHECK, 7=WRONG, 8=CORRECT, 9=DONE.
  int          m_st  = 0;
  int          m_chk = 0;
  int          m_gn  = 0;
  logic        m_won = 1'b0;
  logic [24:0] m_word = '0;
  logic [24:0] m_tgt  = '0;
  logic [9:0]  m_res  = '0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_st <= 0; m_chk <= 0; m_gn <= 0; m_won <= 1'b0;
      m_word <= '0; m_tgt <= '0; m_res <= '0;
    end else begin
      case (m_st)
        0: if (Enter) begin
             m_tgt <= Target; m_word <= '0; m_res <= '0; m_gn <= 0; m_won <= 1'b0; m_st <= 1;
           end
        1, 2, 3, 4, 5:
           if (Enter) begin
             if (CharIn <= 5'd25) begin
               m_word[(m_st-1)*5 +: 5] <= CharIn;
               if (m_st == 5) begin m_st <= 6; m_chk <= 6; end
               else m_st <= m_st + 1;
             end
           end else if (Back && m_st > 1) begin
             m_word[(m_st-2)*5 +: 5] <= 5'd0;
             m_st <= m_st - 1;
           end
        6: begin
             m_chk <= m_chk - 1;
             if (m_chk == 1) begin
               m_res <= score(m_word, m_tgt);
               m_gn  <= m_gn + 1;
               if (score(m_word, m_tgt) == 10'b1010101010) begin m_won <= 1'b1; m_st <= 8; end
               else m_st <= 7;
             end
           end
        7: if (Enter) begin
             if (m_gn == MAXG) m_st <= 9;
             else begin m_word <= '0; m_res <= '0; m_st <= 1; end
           end
        8: if (Enter) m_st <= 9;
        9: if (Enter) m_st <= 0;
        default: m_st <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    chk("flags", {22'd0, q_Done, q_Correct, q_Wrong, q_Check, q_L5, q_L4, q_L3, q_L2, q_L1, q_I},
        32'd1 << m_st);
    chk("guess_word", {7'd0, GuessWord}, {7'd0, m_word});
    chk("guess_number", {29'd0, GuessNumber}, m_gn);
    chk("won", {31'd0, Won}, {31'd0, m_won});
    if (m_st != 6) chk("result", {22'd0, Result}, {22'd0, m_res});
`ifndef WORDLE_HISTORY_EN
    chk("hist_word_tied", {7'd0, HistWord}, 32'd0);
    chk("hist_result_tied", {22'd0, HistResult}, 32'd0);
`endif
  end

  task automatic pulse(input logic en, input logic bk, input logic [4:0] ch);
    Enter = en; Back = bk; CharIn = ch;
    @(posedge Clk); #2;
    Enter = 1'b0; Back = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #2; end
  endtask

  task automatic type_word(input logic [24:0] w);
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, w[i*5 +: 5]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [24:0] crane, eerie, abcde;
  logic [24:0] wtab [4];
  int          n;

  initial begin
    crane = pack(2, 17, 0, 13, 4);
    eerie = pack(4, 4, 17, 8, 4);
    abcde = pack(0, 1, 2, 3, 4);
    wtab[0] = pack(18, 19, 14, 11, 4);
    wtab[1] = pack(13, 0, 2, 17, 4);
    wtab[2] = pack(25, 25, 25, 25, 25);
    wtab[3] = pack(4, 13, 0, 17, 2);
    Target  = crane;

    repeat (2) @(posedge Clk);
    #2 Reset = 1'b0;

    chk("reset_q_I", {31'd0, q_I}, 32'd1);
    chk("reset_guess_number", {29'd0, GuessNumber}, 32'd0);
    chk("reset_result", {22'd0, Result}, 32'd0);
    chk("model_score_crane", {22'd0, score(crane, crane)}, 32'b1010101010);
    chk("model_score_eerie", {22'd0, score(eerie, crane)}, 32'b1000010000);

    // Winning guess and CHECK duration.
    pulse(1'b1, 1'b0, 5'd0);
    type_word(crane);
    n = 0;
    while (q_Check && n < 20) begin n++; @(posedge Clk); #2; end
    chk("check_len", n, 32'd6);
    chk("win_q_Correct", {31'd0, q_Correct}, 32'd1);
    chk("win_result", {22'd0, Result}, 32'b1010101010);
    chk("win_guess_number", {29'd0, GuessNumber}, 32'd1);
    chk("win_won", {31'd0, Won}, 32'd1);
    pulse(1'b1, 1'b0, 5'd0);
    chk("win_done", {31'd0, q_Done}, 32'd1);
    pulse(1'b1, 1'b0, 5'd0);
    chk("back_to_idle", {31'd0, q_I}, 32'd1);

    // Duplicate-letter scoring.
    pulse(1'b1, 1'b0, 5'd0);
    chk("start_clears_won", {31'd0, Won}, 32'd0);
    type_word(eerie);
    idle(6);
    chk("eerie_result", {22'd0, Result}, 32'b1000010000);
    chk("eerie_q_Wrong", {31'd0, q_Wrong}, 32'd1);

    // Letter editing: invalid code, Back, Enter+Back together, Back in L1.
    pulse(1'b1, 1'b0, 5'd0);
    chk("retry_clears_result", {22'd0, Result}, 32'd0);
    pulse(1'b0, 1'b1, 5'd0);
    chk("back_in_l1", {31'd0, q_L1}, 32'd1);
    pulse(1'b1, 1'b0, 5'd0);
    pulse(1'b1, 1'b0, 5'd1);
    pulse(1'b1, 1'b0, 5'd27);
    chk("invalid_stays_l3", {31'd0, q_L3}, 32'd1);
    chk("invalid_word", {7'd0, GuessWord}, 32'h20);
    pulse(1'b0, 1'b1, 5'd0);
    chk("back_to_l2", {31'd0, q_L2}, 32'd1);
    chk("back_clears", {7'd0, GuessWord}, 32'h0);
    pulse(1'b1, 1'b1, 5'd1);
    chk("enter_wins_l3", {31'd0, q_L3}, 32'd1);
    chk("enter_wins_word", {7'd0, GuessWord}, 32'h20);
    pulse(1'b1, 1'b0, 5'd2);
    pulse(1'b1, 1'b0, 5'd3);
    pulse(1'b1, 1'b0, 5'd4);
    idle(6);
    chk("abcde_result", {22'd0, Result}, {22'd0, score(abcde, crane)});

    // Exhaust the guess budget.
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 1'b0, 5'd0);
      type_word(wtab[i]);
      idle(6);
    end
    chk("sixth_guess_number", {29'd0, GuessNumber}, 32'd6);
    chk("sixth_q_Wrong", {31'd0, q_Wrong}, 32'd1);
    pulse(1'b1, 1'b0, 5'd0);
    chk("loss_done", {31'd0, q_Done}, 32'd1);
    chk("loss_won", {31'd0, Won}, 32'd0);
    chk("loss_guess_number", {29'd0, GuessNumber}, 32'd6);
    pulse(1'b1, 1'b0, 5'd0);

    // Reset during the third CHECK cycle of the second guess.
    pulse(1'b1, 1'b0, 5'd0);
    type_word(eerie);
    idle(6);
    pulse(1'b1, 1'b0, 5'd0);
    type_word(abcde);
    idle(2);
    chk("pre_reset_check", {31'd0, q_Check}, 32'd1);
    chk("pre_reset_gn", {29'd0, GuessNumber}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("rst_q_I", {31'd0, q_I}, 32'd1);
    chk("rst_guess_number", {29'd0, GuessNumber}, 32'd0);
    chk("rst_result", {22'd0, Result}, 32'd0);
    chk("rst_q_Check", {31'd0, q_Check}, 32'd0);
    @(posedge Clk); #2;
    Reset = 1'b0;

`ifdef WORDLE_HISTORY_EN
    pulse(1'b1, 1'b0, 5'd0);
    type_word(abcde);
    idle(6);
    pulse(1'b1, 1'b0, 5'd0);
    type_word(eerie);
    idle(9);
    HistSel = 3'd1;
    idle(2);
    chk("hist1_word", {7'd0, HistWord}, {7'd0, eerie});
    chk("hist1_result", {22'd0, HistResult}, 32'b1000010000);
    HistSel = 3'd0;
    idle(2);
    chk("hist0_word", {7'd0, HistWord}, {7'd0, abcde});
    HistSel = 3'd7;
    idle(2);
    chk("hist7_word", {7'd0, HistWord}, 32'd0);
    chk("hist7_result", {22'd0, HistResult}, 32'd0);
`else
    HistSel = 3'd5;
    pulse(1'b1, 1'b0, 5'd0);
    type_word(abcde);
    idle(8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
